video_pattern_gen: RTL and testbench

Synthesizable pixel-stream source for the skin-segmentation video path. Generates de/hsync/vsync timing plus 24-bit RGB test patterns in the same stream format the morphology filters consume, so filters such as the 3x3 closing can run on hardware without a live HDMI receiver. Sits at the head of the pipeline, in place of the HDMI input stage.

---
 rtl/video_pattern_gen_if.sv | 12 +
 rtl/video_pattern_gen.sv | 141 ++++++++++++++
 tb/tb_video_pattern_gen.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/video_pattern_gen_if.sv
// Pixel stream bundle (timing strobes plus 24-bit RGB) in the format the morphology filters consume.
interface video_pattern_gen_if;
  logic       out_de;
  logic       out_hsync;
  logic       out_vsync;
  logic [7:0] out_red;
  logic [7:0] out_green;
  logic [7:0] out_blue;

  modport master (output out_de, out_hsync, out_vsync, out_red, out_green, out_blue);
  modport slave  (input  out_de, out_hsync, out_vsync, out_red, out_green, out_blue);
endinterface

// File: rtl/video_pattern_gen.sv
// Test-pattern pixel source standing in for the HDMI input stage of the skin-segmentation path.
// Define VIDEO_PATGEN_NOISE_EN to turn pattern 3 into LFSR salt-and-pepper noise instead of a gradient.
module video_pattern_gen #(
  parameter logic [9:0] H_SIZE   = 10'd83,
  parameter logic [9:0] H_FP     = 10'd4,
  parameter logic [9:0] H_SYNC   = 10'd8,
  parameter logic [9:0] H_BP     = 10'd4,
  parameter logic [9:0] V_SIZE   = 10'd64,
  parameter logic [9:0] V_FP     = 10'd2,
  parameter logic [9:0] V_SYNC   = 10'd2,
  parameter logic [9:0] V_BP     = 10'd2,
  parameter logic       SYNC_POL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic                enable,
  input  logic [1:0]          pattern,
  video_pattern_gen_if.master vid,
  output logic                frame_start,
  output logic                busy,
  output logic [15:0]         frame_cnt
);

  localparam logic [9:0] H_TOTAL      = H_SIZE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] V_TOTAL      = V_SIZE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_SYNC_START = H_SIZE + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_SIZE + H_FP + H_SYNC;
  localparam logic [9:0] V_SYNC_START = V_SIZE + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_SIZE + V_FP + V_SYNC;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [9:0]  h_cnt, v_cnt, h_d, v_d;
  logic [1:0]  pat_q, pat_cur;
  logic        run_c, first_c, last_c, de_c, hs_c, vs_c;
  logic [23:0] rgb_c;

  assign run_c   = (state_q == RUN);
  assign first_c = run_c && (h_cnt == '0) && (v_cnt == '0);
  assign last_c  = run_c && (h_cnt == H_TOTAL - 10'd1) && (v_cnt == V_TOTAL - 10'd1);
  assign de_c    = run_c && (h_cnt < H_SIZE) && (v_cnt < V_SIZE);
  assign hs_c    = run_c && (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
  assign vs_c    = run_c && (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
  // The first pixel of a frame must already use the newly sampled pattern.
  assign pat_cur = first_c ? pattern : pat_q;

  always_comb begin
    state_d = state_q;
    h_d     = h_cnt;
    v_d     = v_cnt;
    case (state_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (h_cnt == H_TOTAL - 10'd1) begin
          h_d = '0;
          v_d = (v_cnt == V_TOTAL - 10'd1) ? '0 : v_cnt + 10'd1;
        end else begin
          h_d = h_cnt + 10'd1;
        end
        if (last_c && !enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef VIDEO_PATGEN_NOISE_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr_q, lfsr_cur;

  assign lfsr_cur = first_c ? LFSR_SEED : lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (ce && de_c) begin
      lfsr_q <= {lfsr_cur[14:0], lfsr_cur[15] ^ lfsr_cur[13] ^ lfsr_cur[12] ^ lfsr_cur[10]};
    end
  end
`endif

  always_comb begin
    rgb_c = '0;
    if (de_c) begin
      case (pat_cur)
        2'd0:    rgb_c = '0;
        2'd1:    rgb_c = '1;
        2'd2:    rgb_c = (h_cnt[3] ^ v_cnt[3]) ? '0 : '1;
`ifdef VIDEO_PATGEN_NOISE_EN
        default: rgb_c = {24{lfsr_cur[0]}};
`else
        default: rgb_c = {h_cnt[7:0], v_cnt[7:0], 8'h80};
`endif
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_cnt   <= '0;
      v_cnt   <= '0;
      pat_q   <= '0;
    end else if (ce) begin
      state_q <= state_d;
      h_cnt   <= h_d;
      v_cnt   <= v_d;
      if (first_c) pat_q <= pattern;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.out_de    <= 1'b0;
      vid.out_hsync <= ~SYNC_POL;
      vid.out_vsync <= ~SYNC_POL;
      vid.out_red   <= '0;
      vid.out_green <= '0;
      vid.out_blue  <= '0;
      frame_start   <= 1'b0;
      busy          <= 1'b0;
      frame_cnt     <= '0;
    end else if (ce) begin
      vid.out_de    <= de_c;
      vid.out_hsync <= hs_c ? SYNC_POL : ~SYNC_POL;
      vid.out_vsync <= vs_c ? SYNC_POL : ~SYNC_POL;
      vid.out_red   <= rgb_c[23:16];
      vid.out_green <= rgb_c[15:8];
      vid.out_blue  <= rgb_c[7:0];
      frame_start   <= first_c;
      busy          <= run_c;
      if (last_c) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen: cycle-level frame model feeding an expected-value queue.
module tb_video_pattern_gen;

  localparam int HT = 8;
  localparam int FT = 48;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    logic        fs;
    logic        busy;
    logic [15:0] fcnt;
  } obs_t;

  logic        clk, rst_n, ce, enable, en2;
  logic [1:0]  pattern, pat2;
  logic        frame_start, busy, fs2, busy2;
  logic [15:0] frame_cnt, fcnt2;

  video_pattern_gen_if vid();
  video_pattern_gen_if vid2();

  video_pattern_gen #(
    .H_SIZE(10'd4), .H_FP(10'd1), .H_SYNC(10'd2), .H_BP(10'd1),
    .V_SIZE(10'd3), .V_FP(10'd1), .V_SYNC(10'd1), .V_BP(10'd1), .SYNC_POL(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .enable(enable), .pattern(pattern),
    .vid(vid), .frame_start(frame_start), .busy(busy), .frame_cnt(frame_cnt)
  );

  video_pattern_gen #(
    .H_SIZE(10'd16), .H_FP(10'd1), .H_SYNC(10'd2), .H_BP(10'd1),
    .V_SIZE(10'd16), .V_FP(10'd1), .V_SYNC(10'd1), .V_BP(10'd1), .SYNC_POL(1'b1)
  ) u_chk (
    .clk(clk), .rst_n(rst_n), .ce(ce), .enable(en2), .pattern(pat2),
    .vid(vid2), .frame_start(fs2), .busy(busy2), .frame_cnt(fcnt2)
  );

  always #5 clk = ~clk;

  int          ntests, nfail, cyc;
  int          de_n, vs_n, fs_n;
  int          fs_q[$];
  logic [23:0] px_q[$];
  obs_t        exp_q[$];
  logic [24:0] cexp_q[$];

  bit          m_run;
  int          m_pos;
  logic [1:0]  m_pat;
  logic [15:0] m_fcnt;
  logic [15:0] m_lfsr;
  obs_t        m_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_pat = '0; m_fcnt = '0; m_lfsr = 16'hACE1; m_last = '0;
  endtask

  function automatic obs_t sample();
    obs_t g;
    g.de = vid.out_de; g.hs = vid.out_hsync; g.vs = vid.out_vsync;
    g.rgb = {vid.out_red, vid.out_green, vid.out_blue};
    g.fs = frame_start; g.busy = busy; g.fcnt = frame_cnt;
    return g;
  endfunction

  task automatic tick(input logic ce_v, input logic en_v, input logic [1:0] pat_v);
    obs_t e, got;
    int h, v;
    logic [1:0] p;
    ce = ce_v; enable = en_v; pattern = pat_v;
    e = m_last;
    if (ce_v) begin
      e = '0;
      e.fcnt = m_fcnt;
      if (m_run) begin
        h = m_pos % HT;
        v = m_pos / HT;
        if (m_pos == 0) begin
          m_pat = pat_v;
          m_lfsr = 16'hACE1;
        end
        p = m_pat;
        e.de = (h < 4) && (v < 3);
        e.hs = (h >= 5) && (h < 7);
        e.vs = (v == 4);
        e.fs = (m_pos == 0);
        e.busy = 1'b1;
        if (e.de) begin
          case (p)
            2'd0: e.rgb = 24'h000000;
            2'd1: e.rgb = 24'hFFFFFF;
            2'd2: e.rgb = (((h >> 3) & 1) ^ ((v >> 3) & 1)) != 0 ? 24'h000000 : 24'hFFFFFF;
`ifdef VIDEO_PATGEN_NOISE_EN
            default: e.rgb = m_lfsr[0] ? 24'hFFFFFF : 24'h000000;
`else
            default: e.rgb = {8'(h), 8'(v), 8'h80};
`endif
          endcase
          m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
        if (m_pos == FT - 1) begin
          m_fcnt = m_fcnt + 16'd1;
          e.fcnt = m_fcnt;
          if (!en_v) m_run = 0;
        end
        m_pos = (m_pos + 1) % FT;
      end else if (en_v) begin
        m_run = 1;
        m_pos = 0;
      end
    end
    m_last = e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = sample();
    e = exp_q.pop_front();
    chk($sformatf("cyc%0d", cyc), 64'(got), 64'(e));
    if (got.de) begin
      de_n++;
      px_q.push_back(got.rgb);
    end
    if (got.vs) vs_n++;
    if (got.fs && ce_v) begin
      fs_n++;
      fs_q.push_back(cyc);
    end
  endtask

  task automatic clear_stats();
    de_n = 0; vs_n = 0; fs_n = 0;
    fs_q.delete();
    px_q.delete();
  endtask

  task automatic chk_pix(input string tag, input int nticks);
    logic [24:0] ce_exp;
    repeat (nticks) tick(1'b1, 1'b0, 2'd0);
    ce_exp = cexp_q.pop_front();
    chk(tag, 64'({vid2.out_de, vid2.out_red, vid2.out_green, vid2.out_blue}), 64'(ce_exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clk = 0; rst_n = 0; ce = 1; enable = 0; pattern = 0; en2 = 0; pat2 = 0;
    ntests = 0; nfail = 0; cyc = 0;
    model_reset();
    clear_stats();

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 64'(sample()), 64'(obs_t'('0)));
    chk("reset_chk_de", 64'(vid2.out_de), 64'(0));
    rst_n = 1;

    // white frames, enable held for three frames
    repeat (2) tick(1'b1, 1'b0, 2'd1);
    clear_stats();
    repeat (1 + 3 * FT) tick(1'b1, 1'b1, 2'd1);
    chk("de_count_3fr", 64'(de_n), 64'(36));
    chk("vs_count_3fr", 64'(vs_n), 64'(24));
    chk("fs_count_3fr", 64'(fs_n), 64'(3));
    if (fs_q.size() == 3) begin
      chk("fs_gap1", 64'(fs_q[1] - fs_q[0]), 64'(FT));
      chk("fs_gap2", 64'(fs_q[2] - fs_q[1]), 64'(FT));
    end else begin
      chk("fs_q_size", 64'(fs_q.size()), 64'(3));
    end
    chk("fcnt_3fr", 64'(frame_cnt), 64'(3));

    // drop enable ten cycles into the fourth frame
    clear_stats();
    repeat (10) tick(1'b1, 1'b1, 2'd1);
    repeat (60) tick(1'b1, 1'b0, 2'd1);
    chk("drop_de_count", 64'(de_n), 64'(12));
    chk("drop_fcnt", 64'(frame_cnt), 64'(4));
    chk("drop_busy", 64'(busy), 64'(0));

    // pattern 3 for two frames; frames must repeat exactly
    clear_stats();
    repeat (60) tick(1'b1, 1'b1, 2'd3);
    repeat (60) tick(1'b1, 1'b0, 2'd3);
    chk("p3_px_count", 64'(px_q.size()), 64'(24));
    if (px_q.size() == 24) begin
`ifdef VIDEO_PATGEN_NOISE_EN
      chk("p3_first_px", 64'(px_q[0]), 64'(24'hFFFFFF));
`else
      chk("p3_first_px", 64'(px_q[0]), 64'(24'h000080));
`endif
      for (int unsigned i = 0; i < 12; i++)
        chk($sformatf("p3_repeat%0d", i), 64'(px_q[i + 12]), 64'(px_q[i]));
    end
    chk("p3_fcnt", 64'(frame_cnt), 64'(6));

    // 16x16 checker on the second instance, pattern change mid-frame
    en2 = 1; pat2 = 2'd2;
    tick(1'b1, 1'b0, 2'd0);
    cexp_q.push_back({1'b1, 24'hFFFFFF});
    chk_pix("chk_0_0", 1);
    cexp_q.push_back({1'b1, 24'h000000});
    chk_pix("chk_8_0", 8);
    pat2 = 2'd0;
    cexp_q.push_back({1'b1, 24'hFFFFFF});
    chk_pix("chk_8_8", 160);
    cexp_q.push_back({1'b1, 24'h000000});
    chk_pix("chk_next_frame_0_0", 212);
    en2 = 0;

    // ce toggling every cycle, then a mid-frame asynchronous reset
    for (int unsigned i = 0; i < 60; i++) begin
      tick(1'b0, 1'b1, 2'd1);
      tick(1'b1, 1'b1, 2'd1);
    end
    repeat (5) tick(1'b1, 1'b1, 2'd1);
    #2;
    rst_n = 0;
    #1;
    chk("async_reset", 64'(sample()), 64'(obs_t'('0)));
    chk("async_reset_fcnt", 64'(frame_cnt), 64'(0));
    #3;
    rst_n = 1;
    model_reset();
    repeat (4) tick(1'b1, 1'b0, 2'd1);
    repeat (FT + 2) tick(1'b1, 1'b1, 2'd2);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
